// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Two-requester data-memory bus plus the shared memory port.
// Revision : 1.0
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  r0_req;
    logic                  r0_lock;
    logic                  r0_we;
    logic [2:0]            r0_op;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_req;
    logic                  r1_lock;
    logic                  r1_we;
    logic [2:0]            r1_op;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [2:0]            mem_op;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side: serves the requesters and drives the memory port.
    modport slave (
        input  r0_req, r0_lock, r0_we, r0_op, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_lock, r1_we, r1_op, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_en, mem_we, mem_op, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment side: requesters and memory model.
    modport master (
        output r0_req, r0_lock, r0_we, r0_op, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_lock, r1_we, r1_op, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_en, mem_we, mem_op, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter with bounded burst lock sharing one data
//            memory port between two masters; read data routed by tag pipe.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 4
) (
    input  wire logic     clock,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);
    localparam logic [3:0] c_cnt_sat   = 4'hF;

    logic                    r_last;
    logic                    r_owner_valid;
    logic                    r_owner;
    logic [3:0]              r_burst_cnt;
    logic [READ_LATENCY-1:0] r_tag_valid;
    logic [READ_LATENCY-1:0] r_tag_id;

    logic w_owner_req;
    logic w_other_req;
    logic w_owner_lock;
    logic w_hold;
    logic w_gnt0;
    logic w_gnt1;
    logic w_accept;
    logic w_winner_lock;
    logic w_winner_we;

    assign w_owner_req  = r_owner ? bus.r1_req  : bus.r0_req;
    assign w_other_req  = r_owner ? bus.r0_req  : bus.r1_req;
    assign w_owner_lock = r_owner ? bus.r1_lock : bus.r0_lock;

    // A lock only survives contention until the burst budget is spent.
    assign w_hold = r_owner_valid & w_owner_req &
                    (~w_other_req | (r_burst_cnt < c_max_burst));

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (w_hold) begin
                w_gnt0 = ~r_owner;
                w_gnt1 = r_owner;
            end else if (bus.r0_req && bus.r1_req) begin
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
            end else begin
                w_gnt0 = bus.r0_req;
                w_gnt1 = bus.r1_req;
            end
        end
    end

    assign w_accept      = w_gnt0 | w_gnt1;
    assign w_winner_lock = w_gnt1 ? bus.r1_lock : bus.r0_lock;
    assign w_winner_we   = w_gnt1 ? bus.r1_we   : bus.r0_we;

    assign bus.r0_gnt    = w_gnt0;
    assign bus.r1_gnt    = w_gnt1;
    assign bus.mem_en    = w_accept;
    assign bus.mem_we    = w_accept & w_winner_we;
    assign bus.mem_op    = w_gnt1 ? bus.r1_op    : bus.r0_op;
    assign bus.mem_addr  = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
    assign bus.mem_wdata = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last        <= 1'b1;
            r_owner_valid <= 1'b0;
            r_owner       <= 1'b0;
            r_burst_cnt   <= 4'd0;
            r_tag_valid   <= '0;
            r_tag_id      <= '0;
        end else begin
            if (w_accept) begin
                r_last <= w_gnt1;
                if (w_winner_lock) begin
                    if (r_owner_valid && (r_owner == w_gnt1)) begin
                        r_burst_cnt <= (r_burst_cnt == c_cnt_sat) ? c_cnt_sat
                                                                  : r_burst_cnt + 4'd1;
                    end else begin
                        r_owner_valid <= 1'b1;
                        r_owner       <= w_gnt1;
                        r_burst_cnt   <= 4'd1;
                    end
                end else begin
                    r_owner_valid <= 1'b0;
                    r_burst_cnt   <= 4'd0;
                end
            end else if (r_owner_valid && !w_owner_lock) begin
                // Idle owner that released its lock gives up ownership.
                r_owner_valid <= 1'b0;
                r_burst_cnt   <= 4'd0;
            end

            r_tag_valid[0] <= w_accept & ~w_winner_we;
            r_tag_id[0]    <= w_gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_id[i]    <= r_tag_id[i-1];
            end
        end
    end

    assign bus.r0_rvalid = r_tag_valid[READ_LATENCY-1] & ~r_tag_id[READ_LATENCY-1];
    assign bus.r1_rvalid = r_tag_valid[READ_LATENCY-1] &  r_tag_id[READ_LATENCY-1];
    assign bus.r0_rdata  = bus.mem_rdata;
    assign bus.r1_rdata  = bus.mem_rdata;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;
    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int READ_LATENCY = 1;
    localparam int MAX_BURST    = 4;

    logic clock;
    logic reset;

    dmem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    dmem_arbiter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY),
        .MAX_BURST   (MAX_BURST)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents are a fixed function of address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h3C5A, ~a[31:16]};
    endfunction

    logic [31:0] rd_hist [READ_LATENCY];
    always @(posedge clock) begin
        rd_hist[0] <= memfn(bus.mem_addr);
        for (int i = 1; i < READ_LATENCY; i++) rd_hist[i] <= rd_hist[i-1];
    end
    assign bus.mem_rdata = rd_hist[READ_LATENCY-1];

    // Reference model state: who holds a lock, how long its streak is,
    // who won last, and the reads still owed to each requester.
    typedef struct {int due; int id; logic [31:0] data;} rsp_t;
    rsp_t exp_q[$];
    int   m_last, m_owner, m_streak;
    int   cyc;
    int   n_checks, n_errors;

    function automatic int model_winner();
        bit q[2];
        q[0] = bus.r0_req;
        q[1] = bus.r1_req;
        if (m_owner >= 0 && q[m_owner] && (!q[1-m_owner] || m_streak < MAX_BURST))
            return m_owner;
        if (q[0] && q[1]) return 1 - m_last;
        if (q[0]) return 0;
        if (q[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_last   = 1;
        m_owner  = -1;
        m_streak = 0;
        exp_q.delete();
    endtask

    // One clock cycle: inputs are already driven (just after a negedge).
    task automatic run_cycle(output int exp_w, output int obs_w, output int obs_rv);
        logic        lk[2], we[2];
        logic [2:0]  op[2];
        logic [31:0] ad[2], wd[2];
        logic [1:0]  exp_gnt, exp_rv;
        logic [31:0] exp_data;
        #1;
        lk[0] = bus.r0_lock; we[0] = bus.r0_we; op[0] = bus.r0_op; ad[0] = bus.r0_addr; wd[0] = bus.r0_wdata;
        lk[1] = bus.r1_lock; we[1] = bus.r1_we; op[1] = bus.r1_op; ad[1] = bus.r1_addr; wd[1] = bus.r1_wdata;
        exp_w = reset ? -1 : model_winner();
        exp_gnt = (exp_w == 0) ? 2'b01 : (exp_w == 1) ? 2'b10 : 2'b00;
        n_checks++;
        if ({bus.r1_gnt, bus.r0_gnt} !== exp_gnt) begin
            n_errors++;
            $display("FAIL gnt cyc=%0d: got %b expected %b", cyc, {bus.r1_gnt, bus.r0_gnt}, exp_gnt);
        end
        n_checks++;
        if (exp_w >= 0) begin
            if ({bus.mem_en, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata} !==
                {1'b1, we[exp_w], op[exp_w], ad[exp_w], wd[exp_w]}) begin
                n_errors++;
                $display("FAIL mem_cmd cyc=%0d: got en=%b we=%b op=%0h a=%h d=%h expected en=1 we=%b op=%0h a=%h d=%h",
                         cyc, bus.mem_en, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata,
                         we[exp_w], op[exp_w], ad[exp_w], wd[exp_w]);
            end
        end else if ({bus.mem_en, bus.mem_we} !== 2'b00) begin
            n_errors++;
            $display("FAIL mem_idle cyc=%0d: got en=%b we=%b expected 0 0", cyc, bus.mem_en, bus.mem_we);
        end
        exp_rv   = 2'b00;
        exp_data = '0;
        if (!reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_rv   = (exp_q[0].id == 1) ? 2'b10 : 2'b01;
            exp_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        n_checks++;
        if ({bus.r1_rvalid, bus.r0_rvalid} !== exp_rv) begin
            n_errors++;
            $display("FAIL rvalid cyc=%0d: got %b expected %b", cyc, {bus.r1_rvalid, bus.r0_rvalid}, exp_rv);
        end
        if (exp_rv != 2'b00) begin
            n_checks++;
            if ((exp_rv[0] ? bus.r0_rdata : bus.r1_rdata) !== exp_data) begin
                n_errors++;
                $display("FAIL rdata cyc=%0d: got %h expected %h", cyc,
                         exp_rv[0] ? bus.r0_rdata : bus.r1_rdata, exp_data);
            end
        end
        obs_w  = bus.r1_gnt ? 1 : (bus.r0_gnt ? 0 : -1);
        obs_rv = {30'd0, bus.r1_rvalid, bus.r0_rvalid};
        if (reset) begin
            model_reset();
        end else if (exp_w >= 0) begin
            if (!we[exp_w]) exp_q.push_back('{cyc + READ_LATENCY, exp_w, memfn(ad[exp_w])});
            m_last = exp_w;
            if (lk[exp_w]) begin
                if (m_owner == exp_w) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
                else begin m_owner = exp_w; m_streak = 1; end
            end else begin
                m_owner  = -1;
                m_streak = 0;
            end
        end else if (m_owner >= 0 && !lk[m_owner]) begin
            m_owner  = -1;
            m_streak = 0;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.r0_req = 0; bus.r0_lock = 0; bus.r0_we = 0; bus.r0_op = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
        bus.r1_req = 0; bus.r1_lock = 0; bus.r1_we = 0; bus.r1_op = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    endtask

    task automatic do_reset();
        int e, o, rv;
        idle_inputs();
        reset = 1'b1;
        run_cycle(e, o, rv);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int e, o, rv;
        do_reset();
        n_checks++;
        if ({bus.r1_gnt, bus.r0_gnt, bus.r1_rvalid, bus.r0_rvalid, bus.mem_en} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_state: got %b expected 00000",
                     {bus.r1_gnt, bus.r0_gnt, bus.r1_rvalid, bus.r0_rvalid, bus.mem_en});
        end
        run_cycle(e, o, rv);
    endtask

    task automatic test_alternate();
        int e, o, rv;
        int exp_seq[4] = '{0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.r0_req = 1; bus.r0_addr = 32'h1000 + 32'(i);
            bus.r1_req = 1; bus.r1_addr = 32'h2000 + 32'(i);
            run_cycle(e, o, rv);
            n_checks++;
            if (o !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL alternate[%0d]: got winner %0d expected %0d", i, o, exp_seq[i]);
            end
        end
        idle_inputs();
        for (int i = 0; i < READ_LATENCY + 1; i++) run_cycle(e, o, rv);
    endtask

    task automatic test_single_read();
        int e, o, rv;
        do_reset();
        bus.r1_req = 1; bus.r1_addr = 32'h100;
        run_cycle(e, o, rv);
        n_checks++;
        if (o !== 1) begin
            n_errors++;
            $display("FAIL single_gnt: got winner %0d expected 1", o);
        end
        idle_inputs();
        for (int i = 1; i < READ_LATENCY; i++) run_cycle(e, o, rv);
        #1;
        n_checks++;
        if ({bus.r1_rvalid, bus.r0_rvalid, bus.r1_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL single_rsp: got rv=%b data=%h expected rv=10 data=deadbeef",
                     {bus.r1_rvalid, bus.r0_rvalid}, bus.r1_rdata);
        end
        @(negedge clock);
        cyc++;
        void'(exp_q.pop_front());
        run_cycle(e, o, rv);
    endtask

    task automatic test_burst();
        int e, o, rv;
        int exp_seq[6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        bus.r0_req = 1; bus.r0_lock = 1; bus.r0_addr = 32'h40;
        bus.r1_req = 1; bus.r1_addr = 32'h80;
        for (int i = 0; i < 6; i++) begin
            run_cycle(e, o, rv);
            n_checks++;
            if (o !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL burst[%0d]: got winner %0d expected %0d", i, o, exp_seq[i]);
            end
        end
        idle_inputs();
        for (int i = 0; i < READ_LATENCY + 1; i++) run_cycle(e, o, rv);
    endtask

    task automatic test_saturate();
        int e, o, rv, wins;
        do_reset();
        wins = 0;
        bus.r0_req = 1; bus.r0_lock = 1;
        for (int i = 0; i < 18; i++) begin
            bus.r0_addr = 32'h300 + 32'(i);
            run_cycle(e, o, rv);
            if (o == 0) wins++;
        end
        n_checks++;
        if (wins !== 18) begin
            n_errors++;
            $display("FAIL saturate: got %0d grants expected 18", wins);
        end
        idle_inputs();
        for (int i = 0; i < READ_LATENCY + 1; i++) run_cycle(e, o, rv);
    endtask

    task automatic test_write();
        int e, o, rv, seen;
        do_reset();
        bus.r1_req = 1; bus.r1_we = 1; bus.r1_addr = 32'h20;
        bus.r1_wdata = 32'h5A5A5A5A; bus.r1_op = 3'b010;
        #1;
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 1'b1, 3'b010, 32'h20, 32'h5A5A5A5A}) begin
            n_errors++;
            $display("FAIL write_cmd: got en=%b we=%b op=%0h a=%h d=%h expected 1 1 2 00000020 5a5a5a5a",
                     bus.mem_en, bus.mem_we, bus.mem_op, bus.mem_addr, bus.mem_wdata);
        end
        run_cycle(e, o, rv);
        idle_inputs();
        seen = 0;
        for (int i = 0; i < READ_LATENCY + 2; i++) begin
            run_cycle(e, o, rv);
            seen += rv;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL write_no_rvalid: got %0d rvalid cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_inflight();
        int e, o, rv, seen;
        do_reset();
        bus.r0_req = 1; bus.r0_addr = 32'h500;
        run_cycle(e, o, rv);
        bus.r1_req = 1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) run_cycle(e, o, rv);
        reset = 1'b0;
        model_reset();
        idle_inputs();
        seen = 0;
        for (int i = 0; i < READ_LATENCY + 2; i++) begin
            run_cycle(e, o, rv);
            seen += rv;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL stale_rvalid: got %0d rvalid cycles expected 0", seen);
        end
        bus.r0_req = 1; bus.r1_req = 1;
        run_cycle(e, o, rv);
        n_checks++;
        if (o !== 0) begin
            n_errors++;
            $display("FAIL post_reset_tie: got winner %0d expected 0", o);
        end
        idle_inputs();
        for (int i = 0; i < READ_LATENCY + 1; i++) run_cycle(e, o, rv);
    endtask

    task automatic test_random();
        int  e, o, rv;
        bit  pend[2];
        do_reset();
        pend[0] = 0;
        pend[1] = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend[0]) begin
                bus.r0_lock = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 99) < 60) begin
                    pend[0] = 1; bus.r0_req = 1; bus.r0_we = ($urandom_range(0, 3) == 0);
                    bus.r0_op = 3'($urandom); bus.r0_addr = $urandom; bus.r0_wdata = $urandom;
                end else bus.r0_req = 0;
            end
            if (!pend[1]) begin
                bus.r1_lock = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 99) < 60) begin
                    pend[1] = 1; bus.r1_req = 1; bus.r1_we = ($urandom_range(0, 3) == 0);
                    bus.r1_op = 3'($urandom); bus.r1_addr = $urandom; bus.r1_wdata = $urandom;
                end else bus.r1_req = 0;
            end
            run_cycle(e, o, rv);
            if (e >= 0) pend[e] = 0;
        end
        idle_inputs();
        for (int i = 0; i < READ_LATENCY + 1; i++) run_cycle(e, o, rv);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset    = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clock);
        test_reset();
        test_alternate();
        test_single_read();
        test_burst();
        test_saturate();
        test_write();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
